bin_to_bcd_n: RTL and testbench
===============================

BIN_TO_BCD_N -- requirements
Module: bin_to_bcd_n

Interface
REQ-001 SHALL have parameter BIN_W, default 32, binary input width; legal range 4..64.
REQ-002 SHALL have parameter DIGITS, default 10, number of BCD output digits; integrator guarantees 10^DIGITS > 2^BIN_W - 1.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bin_data_i  input  BIN_W  binary value to convert.
REQ-006 SHALL have port bin_valid_i  input  1  bin_data_i valid.
REQ-007 SHALL have port bin_ready_o  output  1  block can accept an input.
REQ-008 SHALL have port bcd_data_o  output  4*DIGITS  packed BCD result, digit 0 in [3:0].
REQ-009 SHALL have port bcd_ndig_o  output  $clog2(DIGITS+1)  count of significant digits, minimum 1.
REQ-010 SHALL have port bcd_sign_o  output  1  result is negative.
REQ-011 SHALL have port bcd_valid_o  output  1  result valid.
REQ-012 SHALL have port bcd_ready_i  input  1  downstream accepts the result.

Function
REQ-013 SHALL implement FSM states IDLE, CONVERT and DONE, with no other reachable state.
REQ-014 SHALL assert bin_ready_o only in IDLE and bcd_valid_o only in DONE.
REQ-015 SHALL, on an edge with bin_valid_i=1 and bin_ready_o=1, capture the operand magnitude, clear the BCD accumulator and the cycle counter, and enter CONVERT.
REQ-016 SHALL, in each CONVERT cycle, add 3 to every BCD digit >= 5, then shift {accumulator, operand} left by 1 with the operand MSB entering the accumulator LSB.
REQ-017 SHALL spend exactly BIN_W cycles in CONVERT, using a counter of width $clog2(BIN_W+1), and then enter DONE.
REQ-018 SHALL raise bcd_valid_o exactly BIN_W+1 rising edges after the accepting edge.
REQ-019 SHALL register bcd_ndig_o during the transition into DONE, computed as the index of the highest nonzero digit + 1, or 1 when the result is zero.
REQ-020 SHALL hold bcd_data_o, bcd_ndig_o and bcd_sign_o stable while in DONE with bcd_ready_i=0, for any number of cycles.
REQ-021 SHALL, on DONE with bcd_ready_i=1, return to IDLE on that edge; bin_ready_o rises in the next cycle, with no same-cycle re-accept.
REQ-022 SHALL ignore bin_valid_i and bin_data_i outside IDLE.
REQ-023 SHALL hold the previous result on the outputs in IDLE and CONVERT; bcd_valid_o=0 marks it as not valid.
REQ-024 SHALL map any illegal state encoding to IDLE on the next edge.

Reset
REQ-025 SHALL, while rstn_i=0, asynchronously force state IDLE and clear counter, operand, accumulator, bcd_data_o, bcd_ndig_o and bcd_sign_o to 0.
REQ-026 SHALL present bin_ready_o=1 and bcd_valid_o=0 during reset.
REQ-027 SHALL, on reset asserted mid-CONVERT or in DONE, abort the conversion with no output and no later valid pulse.

Configuration
REQ-028 SHALL, with macro BIN_TO_BCD_SIGNED_EN defined, treat bin_data_i as two's complement: convert magnitude |x| (the most negative value maps to magnitude 2^(BIN_W-1)) and register bcd_sign_o = input MSB.
REQ-029 SHALL, without BIN_TO_BCD_SIGNED_EN, treat bin_data_i as unsigned, tie bcd_sign_o to 0, and omit the negation logic; the port list is identical in both builds.

Verification
REQ-030 SHALL cover: BIN_W=32, unsigned build, 0xFFFFFFFF -> bcd_data_o=0x4294967295, ndig=10, sign=0, valid exactly 33 edges after accept.
REQ-031 SHALL cover: input 0 -> bcd_data_o=0, ndig=1; input 7 -> 0x0000000007, ndig=1.
REQ-032 SHALL cover: 123456 accepted, bin_valid_i toggled with 99 during CONVERT, bcd_ready_i low 5 cycles in DONE -> result 0x123456 (ndig=6) held stable, the 99 never converted, bin_ready_o=1 one cycle after the ready edge.
REQ-033 SHALL cover: signed build, 0xFFFFFFFF -> sign=1, bcd=1, ndig=1; 0x80000000 -> sign=1, bcd=0x2147483648, ndig=10.
REQ-034 SHALL cover: rstn_i pulsed low at CONVERT cycle 10 -> all outputs 0 immediately, no bcd_valid_o afterwards, bin_ready_o=1 after release.
REQ-035 SHALL cover: BIN_W=8, DIGITS=3, input 255 -> 0x255, ndig=3, latency 9 edges; back-to-back inputs 1 and 200 -> 0x001 then 0x200.

Source files
------------

// File: rtl/bin_to_bcd_n.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle) with valid/ready handshakes.
// Define BIN_TO_BCD_SIGNED_EN to treat bin_data_i as two's complement and report the sign on bcd_sign_o.
module bin_to_bcd_n #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [BIN_W-1:0]             bin_data_i,
  input  logic                         bin_valid_i,
  output logic                         bin_ready_o,
  output logic [4*DIGITS-1:0]          bcd_data_o,
  output logic [$clog2(DIGITS+1)-1:0]  bcd_ndig_o,
  output logic                         bcd_sign_o,
  output logic                         bcd_valid_o,
  input  logic                         bcd_ready_i
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [BIN_W-1:0]    opnd_q,  opnd_d;
  logic [BCD_W-1:0]    acc_q,   acc_d;
  logic [BCD_W-1:0]    bcd_q,   bcd_d;
  logic [NDIG_W-1:0]   ndig_q,  ndig_d;
  logic [BIN_W-1:0]    mag_c;
  logic [BCD_W-1:0]    acc_adj_c;
  logic                accept_c;
  logic                last_c;

  // Index of highest nonzero digit plus one; a zero result still reports one digit.
  function automatic logic [NDIG_W-1:0] sig_digits(input logic [BCD_W-1:0] v);
    logic [NDIG_W-1:0] n;
    n = NDIG_W'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = NDIG_W'(i + 1);
    end
    return n;
  endfunction

`ifdef BIN_TO_BCD_SIGNED_EN
  logic sign_pend_q, sign_pend_d;
  logic sign_q,      sign_d;

  // Most negative input negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_c = bin_data_i;
    if (bin_data_i[BIN_W-1]) mag_c = ~bin_data_i + BIN_W'(1);
  end

  always_comb begin
    sign_pend_d = sign_pend_q;
    sign_d      = sign_q;
    if (accept_c) sign_pend_d = bin_data_i[BIN_W-1];
    if (last_c)   sign_d      = sign_pend_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      sign_pend_q <= sign_pend_d;
      sign_q      <= sign_d;
    end
  end

  assign bcd_sign_o = sign_q;
`else
  assign mag_c      = bin_data_i;
  assign bcd_sign_o = 1'b0;
`endif

  assign accept_c = (state_q == S_IDLE) && bin_valid_i;
  assign last_c   = (state_q == S_CONVERT) && (cnt_q == CNT_W'(BIN_W - 1));

  // Digit correction: any digit >= 5 gets +3 so the following shift carries into the next decade.
  always_comb begin
    acc_adj_c = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    case (state_q)
      S_IDLE: begin
        if (bin_valid_i) begin
          opnd_d  = mag_c;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        acc_d  = {acc_adj_c[BCD_W-2:0], opnd_q[BIN_W-1]};
        opnd_d = {opnd_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_c) begin
          bcd_d   = acc_d;
          ndig_d  = sig_digits(acc_d);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bcd_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
    end
  end

  assign bin_ready_o = (state_q == S_IDLE);
  assign bcd_valid_o = (state_q == S_DONE);
  assign bcd_data_o  = bcd_q;
  assign bcd_ndig_o  = ndig_q;

endmodule

// File: tb/tb_bin_to_bcd_n.sv
// Bench for bin_to_bcd_n: a 32-bit/10-digit and an 8-bit/3-digit instance checked against
// fixed vectors and a decimal reference model (signed expectations when BIN_TO_BCD_SIGNED_EN is set).
module tb_bin_to_bcd_n;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [31:0] a_bin;
  logic        a_bin_v, a_bin_r;
  logic [39:0] a_bcd;
  logic [3:0]  a_nd;
  logic        a_sign, a_bcd_v, a_bcd_r;

  logic [7:0]  b_bin;
  logic        b_bin_v, b_bin_r;
  logic [11:0] b_bcd;
  logic [1:0]  b_nd;
  logic        b_sign, b_bcd_v, b_bcd_r;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_bcd_n #(.BIN_W(32), .DIGITS(10)) u_a (
    .clk_i(clk), .rstn_i(rstn), .bin_data_i(a_bin), .bin_valid_i(a_bin_v), .bin_ready_o(a_bin_r),
    .bcd_data_o(a_bcd), .bcd_ndig_o(a_nd), .bcd_sign_o(a_sign), .bcd_valid_o(a_bcd_v),
    .bcd_ready_i(a_bcd_r));

  bin_to_bcd_n #(.BIN_W(8), .DIGITS(3)) u_b (
    .clk_i(clk), .rstn_i(rstn), .bin_data_i(b_bin), .bin_valid_i(b_bin_v), .bin_ready_o(b_bin_r),
    .bcd_data_o(b_bcd), .bcd_ndig_o(b_nd), .bcd_sign_o(b_sign), .bcd_valid_o(b_bcd_v),
    .bcd_ready_i(b_bcd_r));

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
    int          nd;
    logic        sgn;
    int          stall;
    bit          junk;
  } vec_a_t;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    int          nd;
    logic        sgn;
  } vec_b_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by repeated division by ten.
  function automatic void ref_model(input logic [63:0] x, input int w,
                                    output logic [63:0] bcd, output int nd, output logic s);
    logic [63:0] mag;
    logic [63:0] d;
    mag = x & ((64'd1 << w) - 64'd1);
    s = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    if (mag[w-1]) begin
      s   = 1'b1;
      mag = (64'd1 << w) - mag;
    end
`endif
    bcd = '0;
    nd  = 1;
    for (int i = 0; i < 16; i++) begin
      d = mag % 64'd10;
      bcd[4*i +: 4] = d[3:0];
      if (d != 64'd0) nd = i + 1;
      mag = mag / 64'd10;
    end
  endfunction

  // Latency counts the accepting edge as edge 1, so valid is expected on edge BIN_W+1.
  task automatic run_a(input logic [31:0] x, input logic [39:0] e_bcd, input int e_nd,
                       input logic e_sign, input int stall, input bit junk);
    int edges;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!a_bin_r && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("a_ready_before_accept", 64'(a_bin_r), 64'(1));
    a_bin   = x;
    a_bin_v = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    a_bin_v = 1'b0;
    check("a_busy_not_ready", 64'(a_bin_r), 64'(0));
    while (!a_bcd_v && edges < 100) begin
      if (junk) begin
        a_bin   = 32'd99;
        a_bin_v = ~a_bin_v;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("a_latency", 64'(edges), 64'(33));
    check("a_bcd", 64'(a_bcd), 64'(e_bcd));
    check("a_ndig", 64'(a_nd), 64'(e_nd));
    check("a_sign", 64'(a_sign), 64'(e_sign));
    for (int k = 0; k < stall; k++) begin
      a_bcd_r = 1'b0;
      if (junk) begin
        a_bin   = 32'd99;
        a_bin_v = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check("a_hold_done", 64'({a_bcd_v, a_bcd, a_nd, a_sign}),
            64'({1'b1, e_bcd, 4'(e_nd), e_sign}));
    end
    a_bcd_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_bcd_r = 1'b0;
    check("a_ready_after_handshake", 64'({a_bin_r, a_bcd_v}), 64'(2'b10));
    check("a_hold_in_idle", 64'(a_bcd), 64'(e_bcd));
    a_bin_v = 1'b0;
  endtask

  task automatic run_b(input logic [7:0] x, input logic [11:0] e_bcd, input int e_nd,
                       input logic e_sign);
    int edges;
    int guard;
    guard = 0;
    while (!b_bin_r && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("b_ready_before_accept", 64'(b_bin_r), 64'(1));
    b_bin   = x;
    b_bin_v = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    b_bin_v = 1'b0;
    while (!b_bcd_v && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("b_latency", 64'(edges), 64'(9));
    check("b_result", 64'({b_bcd, b_nd, b_sign}), 64'({e_bcd, 2'(e_nd), e_sign}));
    b_bcd_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_bcd_r = 1'b0;
    check("b_ready_after_handshake", 64'({b_bin_r, b_bcd_v}), 64'(2'b10));
  endtask

  vec_a_t va[5];
  vec_b_t vb[3];

  initial begin
    logic [63:0] r_bcd;
    int          r_nd;
    logic        r_s;
    logic [31:0] x;
    bit          seen_valid;

`ifdef BIN_TO_BCD_SIGNED_EN
    va[0] = '{32'hFFFF_FFFF, 40'h0000000001,  1, 1'b1, 0, 1'b0};
    va[4] = '{32'h8000_0000, 40'h2147483648, 10, 1'b1, 0, 1'b0};
    vb[0] = '{8'd255, 12'h001, 1, 1'b1};
    vb[1] = '{8'd1,   12'h001, 1, 1'b0};
    vb[2] = '{8'd200, 12'h056, 2, 1'b1};
`else
    va[0] = '{32'hFFFF_FFFF, 40'h4294967295, 10, 1'b0, 0, 1'b0};
    va[4] = '{32'h8000_0000, 40'h2147483648, 10, 1'b0, 0, 1'b0};
    vb[0] = '{8'd255, 12'h255, 3, 1'b0};
    vb[1] = '{8'd1,   12'h001, 1, 1'b0};
    vb[2] = '{8'd200, 12'h200, 3, 1'b0};
`endif
    va[1] = '{32'd0,      40'h0000000000, 1, 1'b0, 0, 1'b0};
    va[2] = '{32'd7,      40'h0000000007, 1, 1'b0, 1, 1'b0};
    va[3] = '{32'd123456, 40'h0000123456, 6, 1'b0, 5, 1'b1};

    rstn    = 1'b0;
    a_bin   = '0; a_bin_v = 1'b0; a_bcd_r = 1'b0;
    b_bin   = '0; b_bin_v = 1'b0; b_bcd_r = 1'b0;
    #12;
    check("reset_a_outputs", 64'({a_bin_r, a_bcd_v, a_bcd, a_nd, a_sign}), 64'({1'b1, 1'b0, 45'd0}));
    check("reset_b_outputs", 64'({b_bin_r, b_bcd_v, b_bcd, b_nd, b_sign}), 64'({1'b1, 1'b0, 15'd0}));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) run_a(va[i].bin, va[i].bcd, va[i].nd, va[i].sgn, va[i].stall, va[i].junk);
    // Back-to-back on the narrow instance: next input offered as soon as ready returns.
    @(negedge clk);
    for (int i = 0; i < 3; i++) run_b(vb[i].bin, vb[i].bcd, vb[i].nd, vb[i].sgn);

    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      if (i < 4) x = x >> (8 * i + 4);
      ref_model(64'(x), 32, r_bcd, r_nd, r_s);
      run_a(x, r_bcd[39:0], r_nd, r_s, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 15; i++) begin
      x = 32'($urandom_range(0, 255));
      ref_model(64'(x), 8, r_bcd, r_nd, r_s);
      run_b(x[7:0], r_bcd[11:0], r_nd, r_s);
    end

    // Reset in the middle of a conversion must abort it without a later valid.
    @(negedge clk);
    a_bin   = 32'hDEAD_BEEF;
    a_bin_v = 1'b1;
    @(posedge clk);
    #1 a_bin_v = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("reset_mid_convert", 64'({a_bin_r, a_bcd_v, a_bcd, a_nd, a_sign}), 64'({1'b1, 1'b0, 45'd0}));
    @(negedge clk);
    rstn = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (a_bcd_v) seen_valid = 1'b1;
    end
    check("no_valid_after_abort", 64'(seen_valid), 64'(0));
    check("ready_after_abort", 64'(a_bin_r), 64'(1));

    ref_model(64'(32'd4321), 32, r_bcd, r_nd, r_s);
    run_a(32'd4321, r_bcd[39:0], r_nd, r_s, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
